// File: rtl/cog_ctrx_pkg.sv
// Shared constants for the multi-channel cog counter: mode codes, ctr field
// layout, and the width rules for pin and channel selects.
package cog_ctrx_pkg;

  localparam logic [3:0] MODE_OFF     = 4'd0;
  localparam logic [3:0] MODE_NCO1    = 4'd1;
  localparam logic [3:0] MODE_NCO2    = 4'd2;
  localparam logic [3:0] MODE_DUTY1   = 4'd3;
  localparam logic [3:0] MODE_DUTY2   = 4'd4;
  localparam logic [3:0] MODE_POSLVL  = 4'd5;
  localparam logic [3:0] MODE_POSEDGE = 4'd6;
  localparam logic [3:0] MODE_NEGLVL  = 4'd7;
  localparam logic [3:0] MODE_NEGEDGE = 4'd8;
  localparam logic [3:0] MODE_PERIOD  = 4'd9;
  localparam logic [3:0] MODE_CHAIN   = 4'd10;

  localparam int CTR_MODE_LSB   = 0;
  localparam int CTR_APIN_LSB   = 4;
  localparam int CTR_BPIN_LSB   = 12;
  localparam int CTR_AROUTE_BIT = 20;
  localparam int CTR_BROUTE_BIT = 21;
  localparam int CTR_W          = 22;

  typedef struct packed {
    logic       broute;
    logic       aroute;
    logic [7:0] bpin;
    logic [7:0] apin;
    logic [3:0] mode;
  } ctr_t;

  // Pin indices use only the low pin_w(NPIN) bits of the 8-bit ctr fields.
  function automatic int pin_w(input int npin);
    return (npin <= 2) ? 1 : $clog2(npin);
  endfunction

  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cog_ctrx_chan.sv
// One counter channel: ctr/frq/phs/cap/ovf state, trigger decode, phase
// accumulator with period capture, and this channel's pin output vectors.
module cog_ctrx_chan
  import cog_ctrx_pkg::*;
#(
  parameter int PW   = 32,
  parameter int NPIN = 32
) (
  input  logic            clk_cog,
  input  logic            ena,
  input  logic            wr_en,
  input  logic            setctr,
  input  logic            setfrq,
  input  logic            setphs,
  input  logic            clrovf,
  input  logic [31:0]     data,
  input  logic [NPIN-1:0] pin_in,
  input  logic            cy_in,
  output logic [PW-1:0]   phs,
  output logic [PW-1:0]   cap,
  output logic            ovf,
  output logic            cyq,
  output logic [NPIN-1:0] pin_out,
  output logic [NPIN-1:0] pin_outb
);

  localparam int          PINW   = pin_w(NPIN);
  localparam logic [31:0] NPIN_U = 32'(NPIN);

  ctr_t            ctr_q;
  logic [PW-1:0]   frq_q, cap_q;
  logic [PW:0]     phs_q, sum;
  logic [1:0]      dly_q;
  logic            ovf_q, cyq_q;
  logic [PINW-1:0] apin, bpin;
  logic            apin_ok, bpin_ok, pa;
  logic            trig, smp, capture, outa, outb, wr_phs, add, carry;
  logic [NPIN-1:0] vec_a, vec_b;
  logic            unused_bits;

  assign apin    = ctr_q.apin[PINW-1:0];
  assign bpin    = ctr_q.bpin[PINW-1:0];
  assign apin_ok = 32'(apin) < NPIN_U;
  assign bpin_ok = 32'(bpin) < NPIN_U;
  assign pa      = apin_ok ? pin_in[apin] : 1'b0;

  always_comb begin
    trig    = 1'b0;
    smp     = 1'b0;
    capture = 1'b0;
    outa    = 1'b0;
    outb    = 1'b0;
    case (ctr_q.mode)
      MODE_NCO1:    begin trig = 1'b1; outa = phs_q[PW-1]; end
      MODE_NCO2:    begin trig = 1'b1; outa = phs_q[PW-1]; outb = ~phs_q[PW-1]; end
      MODE_DUTY1:   begin trig = 1'b1; outa = phs_q[PW]; end
      MODE_DUTY2:   begin trig = 1'b1; outa = phs_q[PW]; outb = ~phs_q[PW]; end
      MODE_POSLVL:  begin smp = 1'b1; trig = dly_q[0]; end
      MODE_POSEDGE: begin smp = 1'b1; trig = (dly_q == 2'b01); end
      MODE_NEGLVL:  begin smp = 1'b1; trig = ~dly_q[0]; end
      MODE_NEGEDGE: begin smp = 1'b1; trig = (dly_q == 2'b10); end
      MODE_PERIOD:  begin smp = 1'b1; trig = 1'b1; capture = (dly_q == 2'b01); end
      MODE_CHAIN:   begin trig = cy_in; outa = phs_q[PW-1]; end
      default:      ;
    endcase
  end

  // A write or a capture restart replaces the add, so neither can carry.
  assign sum    = {1'b0, phs_q[PW-1:0]} + {1'b0, frq_q};
  assign carry  = sum[PW];
  assign wr_phs = wr_en & setphs;
  assign add    = trig & ~capture & ~wr_phs;

  always_ff @(posedge clk_cog or negedge ena) begin
    if (!ena) begin
      ctr_q <= '0;
      frq_q <= '0;
      phs_q <= '0;
      cap_q <= '0;
      ovf_q <= 1'b0;
      dly_q <= '0;
      cyq_q <= 1'b0;
    end else begin
      if (wr_en && setctr) ctr_q <= ctr_t'(data[CTR_W-1:0]);
      if (wr_en && setfrq) frq_q <= data[PW-1:0];
      if (wr_phs) begin
        phs_q <= {1'b0, data[PW-1:0]};
      end else if (capture) begin
        cap_q <= phs_q[PW-1:0];
        phs_q <= {1'b0, frq_q};
      end else if (add) begin
        phs_q <= sum;
      end
      if (wr_en && (setphs || clrovf)) ovf_q <= 1'b0;
      else if (add && carry)           ovf_q <= 1'b1;
      cyq_q <= add & carry;
      if (smp) dly_q <= {dly_q[0], pa};
    end
  end

  always_comb begin
    vec_a    = (outa && apin_ok) ? (NPIN'(1) << apin) : '0;
    vec_b    = (outb && bpin_ok) ? (NPIN'(1) << bpin) : '0;
    pin_out  = (ctr_q.aroute ? '0 : vec_a) | (ctr_q.broute ? '0 : vec_b);
    pin_outb = (ctr_q.aroute ? vec_a : '0) | (ctr_q.broute ? vec_b : '0);
  end

  assign phs = phs_q[PW-1:0];
  assign cap = cap_q;
  assign ovf = ovf_q;
  assign cyq = cyq_q;

  assign unused_bits = ^{data[31:CTR_W], ctr_q.apin, ctr_q.bpin};

endmodule

// File: rtl/cog_ctrx.sv
// Multi-channel cog counter: NCH carry-chained channels, OR-merged pin
// outputs and combinational phs/cap read-back for the ALU source mux.
module cog_ctrx
  import cog_ctrx_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int PW   = 32,
  parameter int NPIN = 32
) (
  input  logic                    clk_cog,
  input  logic                    ena,
  input  logic [sel_w(NCH)-1:0]   wr_sel,
  input  logic                    setctr,
  input  logic                    setfrq,
  input  logic                    setphs,
  input  logic                    clrovf,
  input  logic [31:0]             data,
  input  logic [sel_w(NCH)-1:0]   rd_sel,
  input  logic [NPIN-1:0]         pin_in,
  output logic [PW-1:0]           phs_rd,
  output logic [PW-1:0]           cap_rd,
  output logic [NCH-1:0]          ovf,
  output logic [NPIN-1:0]         pin_out,
  output logic [NPIN-1:0]         pin_outb
);

  localparam int SELW = sel_w(NCH);

  logic [NCH-1:0][PW-1:0]   phs_a, cap_a;
  logic [NCH-1:0][NPIN-1:0] po_a, pob_a;
  logic [NCH:0]             cy_link;
  logic                     unused_cy;

  // Channel 0 has no lower neighbour, so its chain input is tied low.
  assign cy_link[0] = 1'b0;
  assign unused_cy  = cy_link[NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    cog_ctrx_chan #(
      .PW   (PW),
      .NPIN (NPIN)
    ) u_chan (
      .clk_cog  (clk_cog),
      .ena      (ena),
      .wr_en    (wr_sel == SELW'(g)),
      .setctr   (setctr),
      .setfrq   (setfrq),
      .setphs   (setphs),
      .clrovf   (clrovf),
      .data     (data),
      .pin_in   (pin_in),
      .cy_in    (cy_link[g]),
      .phs      (phs_a[g]),
      .cap      (cap_a[g]),
      .ovf      (ovf[g]),
      .cyq      (cy_link[g+1]),
      .pin_out  (po_a[g]),
      .pin_outb (pob_a[g])
    );
  end

  always_comb begin
    pin_out  = '0;
    pin_outb = '0;
    for (int i = 0; i < NCH; i++) begin
      pin_out  = pin_out  | po_a[i];
      pin_outb = pin_outb | pob_a[i];
    end
  end

  assign phs_rd = (32'(rd_sel) < 32'(NCH)) ? phs_a[rd_sel] : '0;
  assign cap_rd = (32'(rd_sel) < 32'(NCH)) ? cap_a[rd_sel] : '0;

endmodule
